// File: rtl/alu_arb.sv
// alu_arb: two-port round-robin arbiter in front of a single shared, purely
// combinational ALU. One operation is in flight at a time: accept in IDLE,
// drive the ALU for one EXEC cycle, then hold the captured result in RESP
// until the owning requester takes it.
module alu_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BSR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [BSR_W-1:0] rsp0_bsr,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [BSR_W-1:0] rsp1_bsr,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [BSR_W-1:0] alu_bsr,

    output logic             busy,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               owner;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   y_q;
    logic [BSR_W-1:0]   bsr_q;
    logic               rsp0_valid_q;
    logic               rsp1_valid_q;
    logic               busy_q;
    logic [15:0]        done_cnt;

    logic               any_req;
    logic               grant_id;
    logic               accept;
    logic               rsp_hs;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Round-robin grant: a lone requester wins outright, a tie goes to the
    // port that did not win last time.
    always_comb begin
        any_req  = req0_valid | req1_valid;
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Request payload of the granted port.
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant_id) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // Acceptance is only possible while idle and out of reset; ready is a
    // direct decode of the grant so at most one port sees it.
    assign accept     = rst_n && (state == IDLE) && any_req;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    // Only the owning port's ready can complete the response.
    assign rsp_hs = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

    // Control FSM plus the operand, result and response-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            y_q          <= '0;
            bsr_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    y_q          <= alu_y;
                    bsr_q        <= alu_bsr;
                    rsp0_valid_q <= !owner;
                    rsp1_valid_q <= owner;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Completed-response counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (rsp_hs) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

    // The ALU always sees the most recently latched operation.
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_y     = y_q;
    assign rsp1_y     = y_q;
    assign rsp0_bsr   = bsr_q;
    assign rsp1_bsr   = bsr_q;

    assign busy     = busy_q;
    assign ops_done = done_cnt;

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 Parameter: BSR_W, default 3, width of ALU branch-status vector.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester N presents an op.
REQ-007 req0_ready / req1_ready  out  1 each  request N accepted this cycle.
REQ-008 req0_op / req1_op  in  4 each  ALU opcode (ALU_ADD, ALU_SUB, ALU_SLL, ...).
REQ-009 req0_a, req0_b / req1_a, req1_b  in  WIDTH each  operands.
REQ-010 rsp0_valid / rsp1_valid  out  1 each  result for requester N available.
REQ-011 rsp0_ready / rsp1_ready  in  1 each  requester N consumes result.
REQ-012 rsp0_y / rsp1_y  out  WIDTH each, rsp0_bsr / rsp1_bsr  out  BSR_W each  result and status.
REQ-013 alu_a, alu_b  out  WIDTH, alu_op  out  4  drive the shared ALU.
REQ-014 alu_y  in  WIDTH, alu_bsr  in  BSR_W  combinational ALU outputs.
REQ-015 busy  out  1  high when state != IDLE.
REQ-016 ops_done  out  16  count of completed response handshakes.

Function
REQ-017 FSM states SHALL be IDLE, EXEC and RESP only.
REQ-018 IDLE, one req valid: grant it; both valid: grant port != last_grant (round-robin).
REQ-019 reqN_ready SHALL be high only in IDLE for the granted port, combinationally from the valids; never both high.
REQ-020 On acceptance: latch op, a, b, grant id; set last_grant = id; go to EXEC.
REQ-021 EXEC (one cycle): alu_* driven from latched regs; alu_y/alu_bsr registered at cycle end; go to RESP.
REQ-022 alu_a/alu_b/alu_op SHALL hold the last latched values in IDLE and RESP.
REQ-023 RESP: rsp<id>_valid=1 with registered y/bsr held stable; other port's rsp_valid=0.
REQ-024 RESP with rsp<id>_ready=1: handshake, ops_done += 1, go to IDLE; otherwise stay in RESP.
REQ-025 Latency: accept in cycle N -> rsp_valid high in cycle N+2; minimum 3 cycles per op; no accept while busy.
REQ-026 rsp<id>_ready for the non-owning port or outside RESP SHALL be ignored.
REQ-027 ops_done SHALL wrap from 16'hFFFF to 0.
REQ-028 Opcodes SHALL pass to alu_op unmodified; undefined codes are not filtered.
REQ-029 Arithmetic is entirely the ALU's; the block SHALL not alter y or bsr.

Reset
REQ-030 rst_n low SHALL force IDLE, last_grant=1 (port 0 wins first tie), all ready/valid outputs 0, busy 0, ops_done 0, alu_*/rsp_*_y/bsr and latched regs 0.
REQ-031 Reset asserted mid-EXEC or mid-RESP SHALL abort the in-flight op; no response is produced after release.
REQ-032 First acceptance SHALL be possible in the first clock after rst_n deasserts.

Verification
REQ-033 req0 ALU_ADD a=10 b=10, rsp0_ready=1 -> req0_ready cycle N, rsp0_valid cycle N+2, rsp0_y=20, ops_done=1.
REQ-034 req0 and req1 both valid from reset (req0 ALU_SUB 10,-5; req1 ALU_XOR 32'ha5a5a5a5,32'h5a5a5a5a) -> port0 served first with rsp0_y=15, then port1 with rsp1_y=32'hFFFFFFFF.
REQ-035 Both ports held continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1; ops_done=6.
REQ-036 req1 ALU_SRA 32'hbadcaffe >>4 with rsp1_ready low for 5 cycles -> rsp1_valid held, rsp1_y=32'hfbadcaff stable, busy=1, req0_ready stays 0.
REQ-037 rst_n pulsed low during RESP -> rsp_valid drops immediately, busy=0, ops_done=0; no stale response after release.
REQ-038 ops_done preloaded by 65535 handshakes plus one -> reads 0.
